// File: rtl/seg_decoder_monitor.sv
// Readback monitor for a multiplexed active-low 7-segment bus: filters each
// {sel,seg_n} sample for stability, decodes it and reports digit changes.
module seg_decoder_monitor #(
    parameter int NDIG          = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic [7:0]          seg_n,
    input  logic [2:0]          sel,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     blank_mask,
    output logic [NDIG-1:0]     err_mask,
    output logic [NDIG-1:0]     dp_mask,
    output logic                upd_valid,
    output logic [2:0]          upd_idx,
    output logic [3:0]          upd_nibble,
    output logic                upd_blank,
    output logic                upd_err,
    input  logic                upd_ready,
    output logic                overflow
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);

    logic [10:0] samp_in;
    logic [10:0] samp_q;
    logic        samp_vld_q;
    logic [3:0]  cnt_q;
    logic        done_q;
    logic        match;
    logic        commit;

    logic [2:0]  cur_idx;
    logic [6:0]  lit;
    logic [3:0]  dec_nib;
    logic        dec_blank;
    logic        dec_err;
    logic        dec_dp;
    logic [3:0]  cur_nib;
    logic        changed;

    assign samp_in = {sel, seg_n};
    // The first sample after reset has no predecessor, so it can never match.
    assign match   = samp_vld_q && (samp_in == samp_q);
    assign commit  = (cnt_q == CNT_MAX) && !done_q;

    assign cur_idx = samp_q[10:8];
    assign lit     = ~samp_q[7:1];
    assign dec_dp  = ~samp_q[0];

    always_comb begin
        dec_nib   = '0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (lit)
            7'h7E: dec_nib = 4'h0;
            7'h30: dec_nib = 4'h1;
            7'h6D: dec_nib = 4'h2;
            7'h79: dec_nib = 4'h3;
            7'h33: dec_nib = 4'h4;
            7'h5B: dec_nib = 4'h5;
            7'h5F: dec_nib = 4'h6;
            7'h70: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h73: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h1F: dec_nib = 4'hB;
            7'h4E: dec_nib = 4'hC;
            7'h3D: dec_nib = 4'hD;
            7'h4F: dec_nib = 4'hE;
            7'h47: dec_nib = 4'hF;
            7'h00: dec_blank = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    assign cur_nib = digits[{cur_idx, 2'b00} +: 4];
    assign changed = ({dec_nib, dec_blank, dec_err} !=
                      {cur_nib, blank_mask[cur_idx], err_mask[cur_idx]});

    // Stability filter: one commit per unbroken run of identical samples.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            samp_q     <= '0;
            samp_vld_q <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            samp_q     <= samp_in;
            samp_vld_q <= 1'b1;
            if (match) begin
                if (cnt_q != CNT_MAX)
                    cnt_q <= cnt_q + 4'd1;
                if (commit)
                    done_q <= 1'b1;
            end else begin
                cnt_q  <= '0;
                done_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            digits     <= '0;
            blank_mask <= '1;
            err_mask   <= '0;
            dp_mask    <= '0;
        end else if (commit) begin
            digits[{cur_idx, 2'b00} +: 4] <= dec_nib;
            blank_mask[cur_idx]           <= dec_blank;
            err_mask[cur_idx]             <= dec_err;
            dp_mask[cur_idx]              <= dec_dp;
        end
    end

    // A load wins over the clear, so a commit during an accepting transfer
    // keeps upd_valid high with the new event.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            upd_valid  <= 1'b0;
            upd_idx    <= '0;
            upd_nibble <= '0;
            upd_blank  <= 1'b0;
            upd_err    <= 1'b0;
            overflow   <= 1'b0;
        end else if (commit && changed) begin
            if (!upd_valid || upd_ready) begin
                upd_valid  <= 1'b1;
                upd_idx    <= cur_idx;
                upd_nibble <= dec_nib;
                upd_blank  <= dec_blank;
                upd_err    <= dec_err;
            end else begin
                overflow   <= 1'b1;
            end
        end else if (upd_valid && upd_ready) begin
            upd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_decoder_monitor.sv
// Scoreboard bench for seg_decoder_monitor: directed patterns push expected
// update events; a negedge monitor pops them on every accepted transfer.
module tb_seg_decoder_monitor;

    logic        clk = 1'b0;
    logic        clrn;
    logic [7:0]  seg_n;
    logic [2:0]  sel;
    logic [31:0] digits;
    logic [7:0]  blank_mask, err_mask, dp_mask;
    logic        upd_valid, upd_blank, upd_err, upd_ready, overflow;
    logic [2:0]  upd_idx;
    logic [3:0]  upd_nibble;

    typedef struct packed {
        logic [2:0] idx;
        logic [3:0] nib;
        logic       blank;
        logic       err;
    } ev_t;

    ev_t sb[$];
    int  n_total = 0;
    int  n_pass  = 0;

    localparam logic [7:0] P3    = 8'h0D;  // ~8'hF2, "3"
    localparam logic [7:0] P1    = 8'h9F;  // ~8'h60, "1"
    localparam logic [7:0] P5    = 8'h49;  // "5" (5B)
    localparam logic [7:0] PA    = 8'h11;  // "A" (77)
    localparam logic [7:0] P8    = 8'h01;  // "8" (7F)
    localparam logic [7:0] PG    = 8'hFD;  // ~8'h02, only g lit
    localparam logic [7:0] PBLK  = 8'hFF;
    localparam logic [7:0] PDP   = 8'hFE;

    seg_decoder_monitor #(.NDIG(8), .STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .seg_n      (seg_n),
        .sel        (sel),
        .digits     (digits),
        .blank_mask (blank_mask),
        .err_mask   (err_mask),
        .dp_mask    (dp_mask),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_nibble (upd_nibble),
        .upd_blank  (upd_blank),
        .upd_err    (upd_err),
        .upd_ready  (upd_ready),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " digits"},     digits, 32'h0);
        chk({tag, " blank_mask"}, {24'h0, blank_mask}, 32'hFF);
        chk({tag, " err_mask"},   {24'h0, err_mask}, 32'h0);
        chk({tag, " dp_mask"},    {24'h0, dp_mask}, 32'h0);
        chk({tag, " upd_fields"}, {20'h0, upd_valid, upd_idx, upd_nibble, upd_blank, upd_err, overflow}, 32'h0);
    endtask

    always @(negedge clk) begin
        if (clrn && upd_valid && upd_ready) begin
            ev_t e;
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_event: got idx=%0d nib=%h blank=%b err=%b expected none",
                         upd_idx, upd_nibble, upd_blank, upd_err);
            end else begin
                e = sb.pop_front();
                if ({upd_idx, upd_nibble, upd_blank, upd_err} === e) n_pass++;
                else $display("FAIL event: got idx=%0d nib=%h blank=%b err=%b expected idx=%0d nib=%h blank=%b err=%b",
                              upd_idx, upd_nibble, upd_blank, upd_err, e.idx, e.nib, e.blank, e.err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b0; sel = 3'd0; seg_n = PBLK; upd_ready = 1'b1;
        cyc(2);
        chk_reset_state("reset");
        clrn = 1'b1;
        cyc(1);

        // Basic commit and latency
        sb.push_back('{idx: 3'd3, nib: 4'h3, blank: 1'b0, err: 1'b0});
        sel = 3'd3; seg_n = P3;
        cyc(4);
        chk("lat_before", {31'h0, upd_valid}, 32'd0);
        cyc(1);
        chk("lat_at", {27'h0, upd_valid, upd_idx, upd_nibble[0]}, {27'h0, 1'b1, 3'd3, 1'b1});
        cyc(1);
        chk("pulse_end", {31'h0, upd_valid}, 32'd0);
        chk("digit3", {28'h0, digits[15:12]}, 32'h3);
        chk("blank_t1", {24'h0, blank_mask}, 32'hF7);
        chk("err_t1", {24'h0, err_mask}, 32'h0);

        // Stability filter
        clrn = 1'b0; cyc(1); clrn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            seg_n = (i % 2 == 0) ? P3 : P1;
            cyc(2);
            chk("filter_valid", {31'h0, upd_valid}, 32'd0);
        end
        chk_reset_state("filter");

        // Repeat with glitch, then invalid
        sb.push_back('{idx: 3'd3, nib: 4'h3, blank: 1'b0, err: 1'b0});
        seg_n = P3; cyc(6);
        seg_n = P1; cyc(1);
        seg_n = P3; cyc(7);
        chk("repeat_valid", {31'h0, upd_valid}, 32'd0);
        sb.push_back('{idx: 3'd3, nib: 4'h0, blank: 1'b0, err: 1'b1});
        seg_n = PG; cyc(6);
        chk("err_mask", {24'h0, err_mask}, 32'h08);
        chk("err_digit", {28'h0, digits[15:12]}, 32'h0);

        // Back-pressure
        upd_ready = 1'b0;
        sb.push_back('{idx: 3'd0, nib: 4'h5, blank: 1'b0, err: 1'b0});
        sel = 3'd0; seg_n = P5; cyc(6);
        sel = 3'd1; seg_n = PA; cyc(6);
        chk("bp_held", {24'h0, upd_valid, upd_idx, upd_nibble}, {24'h0, 1'b1, 3'd0, 4'h5});
        chk("bp_overflow", {31'h0, overflow}, 32'd1);
        chk("bp_digits", {24'h0, digits[7:0]}, 32'hA5);
        upd_ready = 1'b1;
        cyc(1);
        chk("bp_drain", {31'h0, upd_valid}, 32'd0);
        cyc(2);
        chk("bp_idle", {31'h0, upd_valid}, 32'd0);

        // Blank, dp, reset mid-count
        sel = 3'd7; seg_n = PBLK; cyc(6);
        chk("blank7", {31'h0, blank_mask[7]}, 32'd1);
        chk("blank7_valid", {31'h0, upd_valid}, 32'd0);
        seg_n = PDP; cyc(6);
        chk("dp7", {24'h0, dp_mask}, 32'h80);
        chk("dp7_valid", {31'h0, upd_valid}, 32'd0);
        sel = 3'd2; seg_n = P8; cyc(2);
        clrn = 1'b0;
        #1;
        chk_reset_state("async_reset");
        cyc(2);
        clrn = 1'b1;
        cyc(2);

        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
